// File: rtl/result_bus_arbiter.sv
// Round-robin arbiter that shares the 24-bit tracker main bus between hash cores,
// sequencing fixed 14-cycle result frames and forwarding host "reset best" requests.
module result_bus_arbiter #(
    parameter int NUM_CORES = 4,
    parameter int IDX_W     = 2,
    parameter int FRAME_LEN = 14
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NUM_CORES-1:0]   req_i,
    input  logic [NUM_CORES*24-1:0] core_data_i,
    output logic [3:0]             word_sel_o,
    output logic [NUM_CORES-1:0]   grant_o,
    output logic [NUM_CORES-1:0]   done_o,
    input  logic                   reset_best_i,
    output logic                   save_selection_o,
    output logic                   reset_best_nonce_o,
    output logic [23:0]            main_bus_o,
    output logic                   busy_o,
    output logic [15:0]            frame_count_o
);

    localparam int K_W = $clog2(FRAME_LEN);
    localparam logic [K_W-1:0] K_LAST = K_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RESET_BEST,
        S_FRAME
    } state_t;

    state_t             state_q, state_d;
    logic [K_W-1:0]     k_q, k_d;
    logic [IDX_W-1:0]   rr_q, rr_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               pending_q, pending_d;
    logic [15:0]        count_q, count_d;

    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W-1:0]   cand;

    logic [NUM_CORES-1:0] grant_d, done_d;
    logic [3:0]           word_sel_d;
    logic                 save_d, reset_nonce_d;
    logic [23:0]          slice;

    // Word requested from the core at frame cycle k: ID, bits-off (held 4 cycles), nonces 0..7.
    function automatic logic [3:0] word_for_k(input logic [K_W-1:0] k);
        if (k == '0)
            return 4'd0;
        else if (k <= K_W'(4))
            return 4'd1;
        else if (k <= K_W'(12))
            return 4'(int'(k) - 3);
        else
            return 4'd9;
    endfunction

    // Walk offsets from the highest down so the requester closest to rr_q is the last write.
    always_comb begin : pick_next
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        pick_found = 1'b0;
        pick_idx   = rr_q;
        cand       = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            cand = IDX_W'((int'(rr_q) + i) % NUM_CORES);
            if (req_i[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin : next_state
        state_d   = state_q;
        k_d       = k_q;
        rr_d      = rr_q;
        idx_d     = idx_q;
        count_d   = count_q;
        pending_d = pending_q | reset_best_i;
        case (state_q)
            S_IDLE: begin
                if (pending_q) begin
                    state_d   = S_RESET_BEST;
                    pending_d = reset_best_i;
                end else if (pick_found) begin
                    state_d = S_FRAME;
                    idx_d   = pick_idx;
                    k_d     = '0;
                end
            end
            S_RESET_BEST: begin
                state_d = S_IDLE;
            end
            S_FRAME: begin
                if (k_q == K_LAST) begin
                    state_d = S_IDLE;
                    k_d     = '0;
                    count_d = count_q + 16'd1;
                    rr_d    = (idx_q == IDX_W'(NUM_CORES - 1)) ? '0 : idx_q + IDX_W'(1);
                end else begin
                    k_d = k_q + K_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered copies line up with state_q/k_q.
    always_comb begin : output_decode
        grant_d       = '0;
        done_d        = '0;
        word_sel_d    = '0;
        save_d        = 1'b0;
        reset_nonce_d = (state_d == S_RESET_BEST);
        if (state_d == S_FRAME) begin
            grant_d    = NUM_CORES'(1) << idx_d;
            save_d     = (k_d == '0);
            word_sel_d = word_for_k(k_d);
            if (k_d == K_LAST)
                done_d = NUM_CORES'(1) << idx_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q            <= S_IDLE;
            k_q                <= '0;
            rr_q               <= '0;
            idx_q              <= '0;
            pending_q          <= 1'b0;
            count_q            <= '0;
            grant_o            <= '0;
            done_o             <= '0;
            word_sel_o         <= '0;
            save_selection_o   <= 1'b0;
            reset_best_nonce_o <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q            <= state_d;
            k_q                <= k_d;
            rr_q               <= rr_d;
            idx_q              <= idx_d;
            pending_q          <= pending_d;
            count_q            <= count_d;
            grant_o            <= grant_d;
            done_o             <= done_d;
            word_sel_o         <= word_sel_d;
            save_selection_o   <= save_d;
            reset_best_nonce_o <= reset_nonce_d;
        end
    end

    assign busy_o        = (state_q != S_IDLE);
    assign frame_count_o = count_q;

    // Only the core ID word is 24 bits wide; all later words carry 16 significant bits.
    always_comb begin : bus_mux
        main_bus_o = '0;
        slice      = core_data_i[int'(idx_q) * 24 +: 24];
        if (word_sel_o != 4'd0)
            slice[23:16] = 8'h00;
        if (state_q == S_FRAME)
            main_bus_o = slice;
    end

endmodule

// File: tb/tb_result_bus_arbiter.sv
// Self-checking bench for result_bus_arbiter: randomized core data and requests
// scored against a frame-level model of the arbitration and word schedule.
module tb_result_bus_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [3:0]  req_i;
    logic [95:0] core_data_i;
    logic [3:0]  word_sel_o;
    logic [3:0]  grant_o;
    logic [3:0]  done_o;
    logic        reset_best_i;
    logic        save_selection_o;
    logic        reset_best_nonce_o;
    logic [23:0] main_bus_o;
    logic        busy_o;
    logic [15:0] frame_count_o;

    int errors = 0;
    int checks = 0;
    int mdl_rr = 0;
    int mdl_count = 0;
    int cyc = 0;

    logic [23:0] core_id [4];
    logic [15:0] bits_off [4];
    logic [15:0] nonce [4][8];

    result_bus_arbiter #(.NUM_CORES(4), .IDX_W(2), .FRAME_LEN(14)) dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .req_i              (req_i),
        .core_data_i        (core_data_i),
        .word_sel_o         (word_sel_o),
        .grant_o            (grant_o),
        .done_o             (done_o),
        .reset_best_i       (reset_best_i),
        .save_selection_o   (save_selection_o),
        .reset_best_nonce_o (reset_best_nonce_o),
        .main_bus_o         (main_bus_o),
        .busy_o             (busy_o),
        .frame_count_o      (frame_count_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Core model: answers whatever word the arbiter selects; upper byte is junk for 16-bit words.
    always_comb begin
        core_data_i = '0;
        for (int n = 0; n < 4; n++) begin
            case (word_sel_o)
                4'd0: core_data_i[n*24 +: 24] = core_id[n];
                4'd1: core_data_i[n*24 +: 24] = {8'hA5, bits_off[n]};
                default: begin
                    if (word_sel_o <= 4'd9)
                        core_data_i[n*24 +: 24] = {8'h5A, nonce[n][int'(word_sel_o) - 2]};
                    else
                        core_data_i[n*24 +: 24] = 24'hBADBAD;
                end
            endcase
        end
    end

    function automatic int exp_grant(input logic [3:0] req, input int rr);
        for (int off = 0; off < 4; off++)
            if (req[(rr + off) % 4]) return (rr + off) % 4;
        return -1;
    endfunction

    function automatic logic [3:0] exp_word(input int k);
        if (k == 0) return 4'd0;
        if (k <= 4) return 4'd1;
        if (k <= 12) return 4'(k - 3);
        return 4'd9;
    endfunction

    function automatic logic [23:0] exp_bus(input int core, input int k);
        int w;
        w = int'(exp_word(k));
        if (w == 0) return core_id[core];
        if (w == 1) return {8'h00, bits_off[core]};
        return {8'h00, nonce[core][w - 2]};
    endfunction

    task automatic randomize_cores();
        for (int n = 0; n < 4; n++) begin
            core_id[n]  = 24'($urandom);
            bits_off[n] = 16'($urandom);
            for (int j = 0; j < 8; j++) nonce[n][j] = 16'($urandom);
        end
    endtask

    task automatic apply_reset();
        rst_i = 1'b0;
        req_i = '0;
        reset_best_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        mdl_rr = 0;
        mdl_count = 0;
    endtask

    task automatic wait_save(output bit ok);
        for (int i = 0; i < 40; i++) begin
            if (save_selection_o === 1'b1) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk_i);
        end
        ok = 1'b0;
        checks++;
        errors++;
        $display("FAIL wait_save timeout: save_selection_o=%b expected 1", save_selection_o);
    endtask

    // Scores one frame from its k=0 cycle, optionally pulsing reset_best_i, dropping or reloading req_i.
    task automatic score_frame(input int core, input logic [13:0] pulse_k, input int drop_k,
                               input logic [3:0] done_req);
        logic [38:0] obs, exp;
        for (int k = 0; k < 14; k++) begin
            exp = {1'b1, (k == 0), 1'b0, 4'(1) << core, (k == 13) ? 4'(1) << core : 4'b0,
                   exp_word(k), exp_bus(core, k)};
            obs = {busy_o, save_selection_o, reset_best_nonce_o, grant_o, done_o, word_sel_o, main_bus_o};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL frame core%0d k=%0d: got %h expected %h", core, k, obs, exp);
            end
            reset_best_i = pulse_k[k];
            if (k == drop_k) req_i = '0;
            if (k == 13) req_i = done_req;
            @(negedge clk_i);
        end
        reset_best_i = 1'b0;
        mdl_count = (mdl_count + 1) % 65536;
        mdl_rr = (core + 1) % 4;
        checks++;
        if ({busy_o, grant_o, frame_count_o} !== {1'b0, 4'b0, 16'(mdl_count)}) begin
            errors++;
            $display("FAIL post_frame busy/grant/count: got %b/%b/%0d expected 0/0000/%0d",
                     busy_o, grant_o, frame_count_o, mdl_count);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        req_i = 4'b1111;
        reset_best_i = 1'b1;
        #3;
        checks++;
        if ({grant_o, done_o, word_sel_o, save_selection_o, reset_best_nonce_o, busy_o, frame_count_o, main_bus_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got grant=%b done=%b sel=%0d busy=%b count=%0d expected all 0",
                     grant_o, done_o, word_sel_o, busy_o, frame_count_o);
        end
        apply_reset();
        checks++;
        if ({busy_o, save_selection_o, reset_best_nonce_o} !== 3'b000) begin
            errors++;
            $display("FAIL reset_release_idle: got %b expected 000", {busy_o, save_selection_o, reset_best_nonce_o});
        end
    endtask

    task automatic test_single();
        bit ok;
        apply_reset();
        core_id[1] = 24'hABCDEF;
        bits_off[1] = 16'd300;
        for (int j = 0; j < 8; j++) nonce[1][j] = 16'h1000 + 16'(j);
        req_i = 4'b0010;
        wait_save(ok);
        if (ok) score_frame(1, '0, -1, 4'b0000);
    endtask

    task automatic test_round_robin();
        bit ok;
        int last_save;
        int order [5] = '{0, 1, 2, 3, 0};
        apply_reset();
        randomize_cores();
        req_i = 4'b1111;
        last_save = -1;
        for (int f = 0; f < 5; f++) begin
            wait_save(ok);
            if (!ok) return;
            checks++;
            if (exp_grant(4'b1111, mdl_rr) != order[f]) begin
                errors++;
                $display("FAIL rr_model f=%0d: got %0d expected %0d", f, exp_grant(4'b1111, mdl_rr), order[f]);
            end
            if (last_save >= 0) begin
                checks++;
                if (cyc - last_save != 15) begin
                    errors++;
                    $display("FAIL rr_spacing f=%0d: got %0d expected 15", f, cyc - last_save);
                end
            end
            last_save = cyc;
            score_frame(order[f], '0, -1, (f == 4) ? 4'b0000 : 4'b1111);
        end
    endtask

    task automatic test_reset_priority();
        bit ok;
        apply_reset();
        randomize_cores();
        req_i = 4'b0001;
        wait_save(ok);
        if (!ok) return;
        score_frame(0, 14'h0040, -1, 4'b0001);
        @(negedge clk_i);
        checks++;
        if ({reset_best_nonce_o, save_selection_o, busy_o} !== 3'b101) begin
            errors++;
            $display("FAIL prio_nonce_pulse: got %b expected 101", {reset_best_nonce_o, save_selection_o, busy_o});
        end
        @(negedge clk_i);
        checks++;
        if ({reset_best_nonce_o, save_selection_o, busy_o} !== 3'b000) begin
            errors++;
            $display("FAIL prio_after_pulse: got %b expected 000", {reset_best_nonce_o, save_selection_o, busy_o});
        end
        @(negedge clk_i);
        wait_save(ok);
        if (ok) score_frame(exp_grant(4'b0001, mdl_rr), '0, -1, 4'b0000);
    endtask

    task automatic test_collapse();
        bit ok;
        int pulses;
        apply_reset();
        randomize_cores();
        req_i = 4'b0100;
        wait_save(ok);
        if (!ok) return;
        score_frame(2, 14'h0224, -1, 4'b0000);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            if (reset_best_nonce_o === 1'b1) pulses++;
            @(negedge clk_i);
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL collapse_pulses: got %0d expected 1", pulses);
        end
    endtask

    task automatic test_drop();
        bit ok;
        randomize_cores();
        req_i = 4'b1000;
        wait_save(ok);
        if (ok) score_frame(3, '0, 3, 4'b0000);
    endtask

    task automatic test_random();
        bit ok;
        logic [3:0] req;
        for (int it = 0; it < 8; it++) begin
            randomize_cores();
            req = 4'($urandom_range(1, 15));
            req_i = req;
            wait_save(ok);
            if (!ok) return;
            score_frame(exp_grant(req, mdl_rr), '0, -1, 4'b0000);
        end
    endtask

    task automatic test_async_reset();
        bit ok;
        randomize_cores();
        req_i = 4'b0001;
        wait_save(ok);
        if (!ok) return;
        repeat (7) @(negedge clk_i);
        #2 rst_i = 1'b0;
        #1;
        checks++;
        if ({grant_o, done_o, word_sel_o, save_selection_o, reset_best_nonce_o, busy_o, frame_count_o, main_bus_o} !== '0) begin
            errors++;
            $display("FAIL async_reset_outputs: got grant=%b done=%b sel=%0d busy=%b count=%0d bus=%h expected all 0",
                     grant_o, done_o, word_sel_o, busy_o, frame_count_o, main_bus_o);
        end
        @(negedge clk_i);
        req_i = 4'b0100;
        @(posedge clk_i);
        #1;
        checks++;
        if ({grant_o, done_o, busy_o} !== 9'b0) begin
            errors++;
            $display("FAIL async_reset_hold: got %b expected 0", {grant_o, done_o, busy_o});
        end
        @(negedge clk_i);
        rst_i = 1'b1;
        mdl_rr = 0;
        mdl_count = 0;
        wait_save(ok);
        if (ok) score_frame(exp_grant(4'b0100, mdl_rr), '0, -1, 4'b0000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b0;
        req_i = '0;
        reset_best_i = 1'b0;
        for (int n = 0; n < 4; n++) begin
            core_id[n] = '0;
            bits_off[n] = '0;
            for (int j = 0; j < 8; j++) nonce[n][j] = '0;
        end
        @(negedge clk_i);
        test_reset();
        test_single();
        test_round_robin();
        test_reset_priority();
        test_collapse();
        test_drop();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/result_bus_arbiter.md
Name: result_bus_arbiter

Overview:
- Shares the 24-bit main bus between NUM_CORES hash cores that report candidate results to the best-nonce tracker.
- Selects one requesting core round-robin and sequences a fixed-length result frame: core ID, bits-off, then 8 nonce words, timed to the tracker's save sequence.
- Also forwards host "reset best" requests to the tracker, but only when no frame is in flight.

Parameters:
NUM_CORES, 4, number of requesting hash cores (2..16)
IDX_W, 2, width of the granted-core index; must equal ceil(log2(NUM_CORES))
FRAME_LEN, 14, cycles per frame (k = 0..FRAME_LEN-1); fixed by the tracker's timing and must not be changed

Ports:
clk_i  in  1  clock; all state updates on the rising edge
rst_i  in  1  asynchronous, active-low reset
req_i  in  NUM_CORES  per-core result-ready request; held high until the matching done_o
core_data_i  in  NUM_CORES*24  per-core data word for the current word_sel_o; core n occupies bits [24n+23:24n]
word_sel_o  out  4  word requested from the granted core: 0 = core ID (24b), 1 = bits-off (16b), 2..9 = nonce words 0..7 (16b)
grant_o  out  NUM_CORES  one-hot grant; high for the whole frame
done_o  out  NUM_CORES  one-cycle one-hot pulse on the last frame cycle
reset_best_i  in  1  host pulse requesting a best-result reset
save_selection_o  out  1  to tracker save_selection; pulses at frame start
reset_best_nonce_o  out  1  to tracker reset input; one-cycle pulse
main_bus_o  out  24  to tracker main bus
busy_o  out  1  high when the arbiter is not IDLE
frame_count_o  out  16  number of completed frames; wraps modulo 2^16

Behaviour:
- Reset (rst_i low, asynchronous):
  - state = IDLE, k = 0, rr pointer = 0, reset-pending = 0.
  - grant_o = 0, done_o = 0, word_sel_o = 0, save_selection_o = 0, reset_best_nonce_o = 0, frame_count_o = 0.
  - A frame in progress is abandoned: no done_o, no count increment.
- Reset pending:
  - Set by reset_best_i in any state.
  - Cleared when the RESET_BEST state is entered.
  - Multiple pulses before service collapse into one.
- States:
  - IDLE:
    - If reset-pending: go to RESET_BEST (reset has priority over grants).
    - Else if req_i != 0: grant the first requester at or after the rr pointer (wrapping NUM_CORES-1 -> 0). Register grant_o and the index, set k = 0, go to FRAME.
    - Else: stay in IDLE.
  - RESET_BEST: reset_best_nonce_o = 1 for exactly one cycle, then IDLE.
  - FRAME (k counts 0..13):
    - k=0: save_selection_o = 1, word_sel_o = 0.
    - k=1..4: word_sel_o = 1 (bits-off; k=2..4 are hold cycles).
    - k=5..12: word_sel_o = 2 + (k-5).
    - k=13: word_sel_o = 9, done_o[granted] = 1, frame_count_o increments, rr pointer = granted index + 1 (mod NUM_CORES).
    - After k=13: grant_o = 0, go to IDLE.
- All control outputs (save_selection_o, reset_best_nonce_o, grant_o, word_sel_o, done_o) are registered and decoded from state and k.
- main_bus_o:
  - Combinational mux of the granted core's 24-bit slice.
  - When word_sel_o != 0, bits [23:16] are forced to 0.
  - Outside FRAME, main_bus_o = 0.
- Frame spacing: minimum 15 cycles between save_selection_o pulses (14 frame cycles plus 1 IDLE). This meets the tracker's 14-cycle return to IDLE.
- The frame always runs its full length, whether or not the tracker accepts the result.
- req_i dropping mid-frame does not abort the frame; done_o still pulses.
- A granted core's req_i still high in the cycle after its done_o is treated as a new request.
- reset_best_i during FRAME is deferred until after k=13 and the following IDLE cycle. It is never issued inside a frame.
- No tracker reset is issued while save_selection_o is active, and both pulses are never high in the same cycle.

Test Plan:
- Single request: req_i = 4'b0010, core 1 ID = 24'hABCDEF, bits-off = 300, nonces = 16'h1000..1007 -> k=0: save_selection_o = 1, main_bus_o = ABCDEF; k=1: main_bus_o = 00012C; k=5..12: main_bus_o = 001000..001007; done_o = 4'b0010 at k=13; frame_count_o = 1.
- Round-robin fairness: req_i = 4'b1111 held -> grant order 0, 1, 2, 3, 0; save_selection_o pulses exactly 15 cycles apart.
- Reset priority: reset_best_i pulsed at k=6 with req_i = 4'b0001 held -> reset_best_nonce_o pulses once, the cycle after the post-frame IDLE; the next grant follows it; never overlaps save_selection_o.
- Collapse: three reset_best_i pulses during one frame -> exactly one reset_best_nonce_o.
- Async reset mid-frame: rst_i low at k=7 -> all outputs 0 immediately, no done_o; after release with req_i = 4'b0100, the core-2 frame starts from k=0.
- Request drop: req_i cleared at k=3 -> frame completes, done_o at k=13, frame_count_o increments.
